// File: rtl/ir_pkg.sv
// Shared types and constants for the IR camera sequencer: FSM encoding,
// transaction descriptor, init table and poll register/read length.
package ir_pkg;

  typedef enum logic [3:0] {
    IDLE,
    PWRUP,
    INIT_REQ,
    INIT_WAIT,
    INIT_GAP,
    POLL_REQ,
    POLL_WAIT,
    POLL_GAP,
    ERROR
  } state_t;

  localparam int unsigned INIT_LEN = 6;
  localparam logic [7:0]  POLL_REG = 8'h36;
  localparam logic [3:0]  READ_LEN = 4'd12;

  // One I2C transaction as presented to the engine.
  typedef struct packed {
    logic       rw;
    logic [7:0] reg_a;
    logic [7:0] wdata;
    logic [3:0] rlen;
  } xact_t;

  // Camera bring-up writes, issued in index order.
  function automatic xact_t init_xact(input logic [2:0] idx);
    xact_t x;
    x.rw   = 1'b0;
    x.rlen = 4'd0;
    case (idx)
      3'd0:    {x.reg_a, x.wdata} = 16'h3001;
      3'd1:    {x.reg_a, x.wdata} = 16'h3008;
      3'd2:    {x.reg_a, x.wdata} = 16'h0690;
      3'd3:    {x.reg_a, x.wdata} = 16'h08C0;
      3'd4:    {x.reg_a, x.wdata} = 16'h1A40;
      default: {x.reg_a, x.wdata} = 16'h3333;
    endcase
    return x;
  endfunction

  // Poll is a pointer write of POLL_REG followed by a READ_LEN-byte read.
  function automatic xact_t poll_xact(input logic rd);
    xact_t x;
    x.rw    = rd;
    x.reg_a = POLL_REG;
    x.wdata = 8'h00;
    x.rlen  = rd ? READ_LEN : 4'd0;
    return x;
  endfunction

endpackage

// File: rtl/ir_cam_sequencer_if.sv
// Request/response bundle between the sequencer and the I2C engine.
interface ir_cam_sequencer_if;
  logic       i2c_req;
  logic       i2c_rw;
  logic [6:0] i2c_dev;
  logic [7:0] i2c_reg;
  logic [7:0] i2c_wdata;
  logic [3:0] i2c_rlen;
  logic       i2c_busy;
  logic       i2c_done;
  logic       i2c_nack;
  logic       i2c_rvalid;
  logic [7:0] i2c_rdata;

  modport master (
    output i2c_req, i2c_rw, i2c_dev, i2c_reg, i2c_wdata, i2c_rlen,
    input  i2c_busy, i2c_done, i2c_nack, i2c_rvalid, i2c_rdata
  );

  modport slave (
    input  i2c_req, i2c_rw, i2c_dev, i2c_reg, i2c_wdata, i2c_rlen,
    output i2c_busy, i2c_done, i2c_nack, i2c_rvalid, i2c_rdata
  );
endinterface

// File: rtl/ir_blob_unpack.sv
// Decodes the 12-byte blob report into shadow registers and publishes
// them to the outputs only when a complete, acknowledged read commits.
module ir_blob_unpack
  import ir_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        rvalid,
  input  logic [7:0]  rdata,
  input  logic        clear,
  input  logic        commit,
  output logic [39:0] blob_x,
  output logic [39:0] blob_y,
  output logic [15:0] blob_size,
  output logic        frame_valid
);

  logic [3:0]  cnt_q;   // bytes seen this read, saturating
  logic [1:0]  pos_q;   // byte position within a blob triple
  logic [1:0]  blk_q;   // blob index 0..3
  logic [39:0] sx_q, sy_q;
  logic [15:0] ss_q;
  logic [39:0] ox_q, oy_q;
  logic [15:0] os_q;
  logic        fv_q;

  // Byte capture into the shadow set, and shadow-to-output commit.
  always_ff @(posedge clk) begin
    // NOTE: the shadow set is reset along with the outputs so a commit can never publish X.
    if (rst) begin
      cnt_q <= '0;
      pos_q <= '0;
      blk_q <= '0;
      sx_q  <= '1;
      sy_q  <= '1;
      ss_q  <= '1;
      ox_q  <= '1;
      oy_q  <= '1;
      os_q  <= '1;
      fv_q  <= 1'b0;
    end else begin
      fv_q <= 1'b0;
      if (clear) begin
        cnt_q <= '0;
        pos_q <= '0;
        blk_q <= '0;
      end else if (rvalid && cnt_q != 4'hF) begin
        cnt_q <= cnt_q + 4'd1;
        if (cnt_q < READ_LEN) begin
          case (pos_q)
            2'd0: sx_q[10*int'(blk_q) +: 8] <= rdata;
            2'd1: sy_q[10*int'(blk_q) +: 8] <= rdata;
            default: begin
              sx_q[10*int'(blk_q)+8 +: 2] <= rdata[5:4];
              sy_q[10*int'(blk_q)+8 +: 2] <= rdata[7:6];
              ss_q[4*int'(blk_q) +: 4]    <= rdata[3:0];
            end
          endcase
          if (pos_q == 2'd2) begin
            pos_q <= 2'd0;
            blk_q <= blk_q + 2'd1;
          end else begin
            pos_q <= pos_q + 2'd1;
          end
        end
      end
      if (commit && cnt_q == READ_LEN) begin
        ox_q <= sx_q;
        oy_q <= sy_q;
        os_q <= ss_q;
        fv_q <= 1'b1;
      end
    end
  end

  assign blob_x      = ox_q;
  assign blob_y      = oy_q;
  assign blob_size   = os_q;
  assign frame_valid = fv_q;

endmodule

// File: rtl/ir_cam_sequencer.sv
// IR camera sequencer: power-up wait, init table, then endless poll
// write/read pairs with per-transaction retry and a sticky error state.
module ir_cam_sequencer
  import ir_pkg::*;
#(
  parameter logic [6:0]  DEV_ADDR  = 7'h58,
  parameter int unsigned PWRUP_CYC = 1_000_000,
  parameter int unsigned GAP_CYC   = 5_000,
  parameter int unsigned MAX_RETRY = 3
) (
  input  logic                ref_clk,
  input  logic                rst,
  input  logic                en,
  ir_cam_sequencer_if.master  i2c,
  output logic [39:0]         blob_x,
  output logic [39:0]         blob_y,
  output logic [15:0]         blob_size,
  output logic                frame_valid,
  output logic                init_done,
  output logic                error
);

  localparam logic [31:0] PWRUP_LAST = 32'(PWRUP_CYC - 1);
  localparam logic [31:0] GAP_LAST   = 32'(GAP_CYC - 1);
  localparam logic [3:0]  RETRY_MAX  = 4'(MAX_RETRY);
  localparam logic [2:0]  INIT_LAST  = 3'(INIT_LEN - 1);

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [3:0]  retry_q, retry_d;
  logic        poll_rd_q, poll_rd_d;
  logic        init_done_q, init_done_d;
  logic        error_q, error_d;
  logic        req_q, req_d;
  xact_t       x_q, x_d;
  logic        commit, clear, rvalid_g;

  // Next-state, counters and request fields.
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    retry_d     = retry_q;
    poll_rd_d   = poll_rd_q;
    init_done_d = init_done_q;
    error_d     = error_q;
    x_d         = x_q;
    commit      = 1'b0;

    unique case (state_q)
      IDLE: if (en) state_d = PWRUP;
      PWRUP: begin
        if (!en) state_d = IDLE;
        else if (cnt_q == PWRUP_LAST) begin
          cnt_d   = '0;
          state_d = INIT_REQ;
        end else cnt_d = cnt_q + 32'd1;
      end
      INIT_REQ, POLL_REQ: begin
        // An accepted request must be seen through to i2c_done even if en drops.
        if (i2c.i2c_busy) state_d = (state_q == INIT_REQ) ? INIT_WAIT : POLL_WAIT;
        else if (!en) state_d = IDLE;
      end
      INIT_WAIT, POLL_WAIT: begin
        if (i2c.i2c_done) begin
          commit = (state_q == POLL_WAIT) && poll_rd_q && !i2c.i2c_nack;
          if (!en) state_d = IDLE;
          else if (!i2c.i2c_nack) begin
            retry_d = '0;
            if (state_q == POLL_WAIT) begin
              poll_rd_d = ~poll_rd_q;
              state_d   = POLL_GAP;
            end else if (idx_q == INIT_LAST) begin
              init_done_d = 1'b1;
              state_d     = POLL_REQ;
            end else begin
              idx_d   = idx_q + 3'd1;
              state_d = INIT_GAP;
            end
          end else begin
            retry_d = retry_q + 4'd1;
            if (retry_q + 4'd1 >= RETRY_MAX) begin
              error_d = 1'b1;
              state_d = ERROR;
            end else state_d = (state_q == INIT_WAIT) ? INIT_GAP : POLL_GAP;
          end
        end
      end
      INIT_GAP, POLL_GAP: begin
        if (!en) state_d = IDLE;
        else if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = (state_q == INIT_GAP) ? INIT_REQ : POLL_REQ;
        end else cnt_d = cnt_q + 32'd1;
      end
      ERROR: if (!en) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Any return to IDLE wipes progress and status; blob outputs are untouched.
    if (state_d == IDLE) begin
      cnt_d       = '0;
      idx_d       = '0;
      retry_d     = '0;
      poll_rd_d   = 1'b0;
      init_done_d = 1'b0;
      error_d     = 1'b0;
    end

    req_d = (state_d == INIT_REQ) || (state_d == POLL_REQ);
    if (state_d == INIT_REQ) x_d = init_xact(idx_d);
    if (state_d == POLL_REQ) x_d = poll_xact(poll_rd_d);
  end

  // State and output registers; rst overrides en and all engine inputs.
  always_ff @(posedge ref_clk) begin
    // NOTE: sequential state uses non-blocking assignment so all registers update together.
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      retry_q     <= '0;
      poll_rd_q   <= 1'b0;
      init_done_q <= 1'b0;
      error_q     <= 1'b0;
      req_q       <= 1'b0;
      x_q         <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      retry_q     <= retry_d;
      poll_rd_q   <= poll_rd_d;
      init_done_q <= init_done_d;
      error_q     <= error_d;
      req_q       <= req_d;
      x_q         <= x_d;
    end
  end

  assign clear    = (state_q == POLL_REQ);
  assign rvalid_g = i2c.i2c_rvalid && (state_q == POLL_WAIT) && poll_rd_q;

  ir_blob_unpack u_unpack (
    .clk        (ref_clk),
    .rst        (rst),
    .rvalid     (rvalid_g),
    .rdata      (i2c.i2c_rdata),
    .clear      (clear),
    .commit     (commit),
    .blob_x     (blob_x),
    .blob_y     (blob_y),
    .blob_size  (blob_size),
    .frame_valid(frame_valid)
  );

  assign i2c.i2c_req   = req_q;
  assign i2c.i2c_rw    = x_q.rw;
  assign i2c.i2c_dev   = DEV_ADDR;
  assign i2c.i2c_reg   = x_q.reg_a;
  assign i2c.i2c_wdata = x_q.wdata;
  assign i2c.i2c_rlen  = x_q.rlen;
  assign init_done     = init_done_q;
  assign error         = error_q;

endmodule

// File: tb/tb_ir_cam_sequencer.sv
// Directed bench for ir_cam_sequencer with a hand-driven I2C engine.
module tb_ir_cam_sequencer;
  import ir_pkg::*;

  logic        ref_clk = 1'b0;
  logic        rst, en;
  logic [39:0] blob_x, blob_y;
  logic [15:0] blob_size;
  logic        frame_valid, init_done, error;
  int          vectors = 0;
  int          miscompares = 0;
  logic [7:0]  rd_bytes [12];

  ir_cam_sequencer_if bus ();

  ir_cam_sequencer #(
    .DEV_ADDR (7'h58),
    .PWRUP_CYC(10),
    .GAP_CYC  (4),
    .MAX_RETRY(3)
  ) dut (
    .ref_clk    (ref_clk),
    .rst        (rst),
    .en         (en),
    .i2c        (bus.master),
    .blob_x     (blob_x),
    .blob_y     (blob_y),
    .blob_size  (blob_size),
    .frame_valid(frame_valid),
    .init_done  (init_done),
    .error      (error)
  );

  always #5 ref_clk = ~ref_clk;

  task automatic check(input string tag, input logic [39:0] got, input logic [39:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_req(output bit ok);
    int n = 0;
    while (!bus.i2c_req && n < 200) begin
      @(negedge ref_clk);
      n++;
    end
    ok = bus.i2c_req;
  endtask

  // Accept one request, check its fields, return nbytes and optionally finish it.
  task automatic serve(input string tag, input logic rw_e, input logic [7:0] reg_e,
                       input logic [7:0] wd_e, input logic [3:0] rlen_e,
                       input bit nack, input int nbytes, input bit finish);
    bit ok;
    wait_req(ok);
    check({tag, "_req"}, 40'(ok), 40'd1);
    check({tag, "_fields"}, {bus.i2c_dev, bus.i2c_rw, bus.i2c_reg, bus.i2c_wdata, bus.i2c_rlen},
          {7'h58, rw_e, reg_e, wd_e, rlen_e});
    bus.i2c_busy = 1'b1;
    @(negedge ref_clk);
    bus.i2c_busy = 1'b0;
    check({tag, "_drop"}, 40'(bus.i2c_req), 40'd0);
    for (int i = 0; i < nbytes; i++) begin
      bus.i2c_rvalid = 1'b1;
      bus.i2c_rdata  = rd_bytes[i];
      @(negedge ref_clk);
      bus.i2c_rvalid = 1'b0;
    end
    if (finish) begin
      bus.i2c_done = 1'b1;
      bus.i2c_nack = nack;
      @(negedge ref_clk);
      bus.i2c_done = 1'b0;
      bus.i2c_nack = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en  = 1'b0;
    repeat (3) @(negedge ref_clk);
    rst = 1'b0;
  endtask

  initial begin
    int cyc;
    rd_bytes = '{8'h10, 8'h20, 8'h35, 8'h01, 8'h02, 8'hC6,
                 8'hAA, 8'h55, 8'h3F, 8'hFF, 8'h00, 8'h90};
    bus.i2c_busy = 1'b0; bus.i2c_done = 1'b0; bus.i2c_nack = 1'b0;
    bus.i2c_rvalid = 1'b0; bus.i2c_rdata = 8'h00;
    rst = 1'b1; en = 1'b0;
    @(negedge ref_clk);
    do_reset();

    // Reset state
    check("rst_state", 40'(dut.state_q), 40'(IDLE));
    check("rst_flags", {37'd0, frame_valid, init_done, error}, 40'd0);
    check("rst_req", 40'(bus.i2c_req), 40'd0);
    check("rst_fields", {bus.i2c_rw, bus.i2c_reg, bus.i2c_wdata, bus.i2c_rlen}, 40'd0);
    check("rst_bx", blob_x, {40{1'b1}});
    check("rst_by", blob_y, {40{1'b1}});
    check("rst_bs", 40'(blob_size), 40'hFFFF);

    // Power-up latency: first request 11 cycles after en
    en = 1'b1;
    cyc = 0;
    while (!bus.i2c_req && cyc < 50) begin
      @(negedge ref_clk);
      cyc++;
    end
    check("pwrup_lat", 40'(cyc), 40'd11);

    // Init table, all acknowledged
    serve("init0", 1'b0, 8'h30, 8'h01, 4'd0, 1'b0, 0, 1'b1);
    serve("init1", 1'b0, 8'h30, 8'h08, 4'd0, 1'b0, 0, 1'b1);
    serve("init2", 1'b0, 8'h06, 8'h90, 4'd0, 1'b0, 0, 1'b1);
    serve("init3", 1'b0, 8'h08, 8'hC0, 4'd0, 1'b0, 0, 1'b1);
    serve("init4", 1'b0, 8'h1A, 8'h40, 4'd0, 1'b0, 0, 1'b1);
    check("pre_init_done", 40'(init_done), 40'd0);
    serve("init5", 1'b0, 8'h33, 8'h33, 4'd0, 1'b0, 0, 1'b1);
    check("init_done", 40'(init_done), 40'd1);

    // Poll write then full read
    serve("pollw0", 1'b0, 8'h36, 8'h00, 4'd0, 1'b0, 0, 1'b1);
    serve("pollr0", 1'b1, 8'h36, 8'h00, 4'd12, 1'b0, 12, 1'b0);
    check("pre_commit_bx", blob_x, {40{1'b1}});
    bus.i2c_done = 1'b1;
    @(negedge ref_clk);
    bus.i2c_done = 1'b0;
    check("fv_pulse", 40'(frame_valid), 40'd1);
    check("b0", {blob_x[9:0], blob_y[9:0], 16'(blob_size[3:0])}, {10'h310, 10'h020, 16'h5});
    check("b1", {blob_x[19:10], blob_y[19:10], 16'(blob_size[7:4])}, {10'h001, 10'h302, 16'h6});
    check("b2", {blob_x[29:20], blob_y[29:20], 16'(blob_size[11:8])}, {10'h3AA, 10'h055, 16'hF});
    check("b3", {blob_x[39:30], blob_y[39:30], 16'(blob_size[15:12])}, {10'h1FF, 10'h200, 16'h0});
    @(negedge ref_clk);
    check("fv_single", 40'(frame_valid), 40'd0);

    // Short read: outputs hold, no pulse
    rd_bytes[0] = 8'h77;
    serve("pollw1", 1'b0, 8'h36, 8'h00, 4'd0, 1'b0, 0, 1'b1);
    serve("pollr1_short", 1'b1, 8'h36, 8'h00, 4'd12, 1'b0, 5, 1'b1);
    check("short_fv", 40'(frame_valid), 40'd0);
    check("short_hold", 40'(blob_x[9:0]), 40'h310);

    // NACKed full read: outputs hold, same read reissued
    serve("pollw2", 1'b0, 8'h36, 8'h00, 4'd0, 1'b0, 0, 1'b1);
    serve("pollr2_nack", 1'b1, 8'h36, 8'h00, 4'd12, 1'b1, 12, 1'b1);
    check("nack_fv", 40'(frame_valid), 40'd0);
    check("nack_hold", 40'(blob_x[9:0]), 40'h310);

    // Reissued read accepted, then rst during POLL_WAIT
    serve("pollr2_retry", 1'b1, 8'h36, 8'h00, 4'd12, 1'b0, 0, 1'b0);
    check("in_poll_wait", 40'(dut.state_q), 40'(POLL_WAIT));
    rst = 1'b1;
    en  = 1'b0;
    @(negedge ref_clk);
    check("rstw_state", 40'(dut.state_q), 40'(IDLE));
    check("rstw_bx", blob_x, {40{1'b1}});
    check("rstw_by", blob_y, {40{1'b1}});
    check("rstw_init_done", 40'(init_done), 40'd0);
    rst = 1'b0;
    bus.i2c_done = 1'b1;
    @(negedge ref_clk);
    bus.i2c_done = 1'b0;
    @(negedge ref_clk);
    check("stray_done_state", 40'(dut.state_q), 40'(IDLE));
    check("stray_done_out", {38'd0, frame_valid, bus.i2c_req}, 40'd0);

    // Third init write NACKed twice then ACKed
    en = 1'b1;
    serve("b_init0", 1'b0, 8'h30, 8'h01, 4'd0, 1'b0, 0, 1'b1);
    serve("b_init1", 1'b0, 8'h30, 8'h08, 4'd0, 1'b0, 0, 1'b1);
    serve("b_init2a", 1'b0, 8'h06, 8'h90, 4'd0, 1'b1, 0, 1'b1);
    serve("b_init2b", 1'b0, 8'h06, 8'h90, 4'd0, 1'b1, 0, 1'b1);
    serve("b_init2c", 1'b0, 8'h06, 8'h90, 4'd0, 1'b0, 0, 1'b1);
    check("b_no_error", 40'(error), 40'd0);
    serve("b_init3", 1'b0, 8'h08, 8'hC0, 4'd0, 1'b0, 0, 1'b1);
    en = 1'b0;
    @(negedge ref_clk);
    check("b_en_off", 40'(dut.state_q), 40'(IDLE));

    // Third init write NACKed three times -> ERROR
    en = 1'b1;
    serve("c_init0", 1'b0, 8'h30, 8'h01, 4'd0, 1'b0, 0, 1'b1);
    serve("c_init1", 1'b0, 8'h30, 8'h08, 4'd0, 1'b0, 0, 1'b1);
    serve("c_init2a", 1'b0, 8'h06, 8'h90, 4'd0, 1'b1, 0, 1'b1);
    serve("c_init2b", 1'b0, 8'h06, 8'h90, 4'd0, 1'b1, 0, 1'b1);
    serve("c_init2c", 1'b0, 8'h06, 8'h90, 4'd0, 1'b1, 0, 1'b1);
    check("c_error", 40'(error), 40'd1);
    cyc = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.i2c_req) cyc++;
      @(negedge ref_clk);
    end
    check("c_req_held", 40'(cyc), 40'd0);
    check("c_error_sticky", 40'(error), 40'd1);
    en = 1'b0;
    @(negedge ref_clk);
    check("c_idle", 40'(dut.state_q), 40'(IDLE));
    check("c_error_clr", 40'(error), 40'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
